// File: rtl/frame_bank_mgr.sv
// frame_bank_mgr: frame bank manager between the 2-FIFO SDRAM controller and
// the LCD timing generator. Picks the SDRAM write/read banks, issues
// address-reload pulses and runs single, double or triple (latest-frame)
// buffering.
//
// Ports:
//   clk_ref, rst                 SDRAM controller clock, async active-high reset
//   enable                       start operation (sdram_init_done)
//   mode[1:0]                    0 single, 1 double, 2/3 triple (latest frame)
//   freeze                       keep the displayed frame, writer keeps going
//   frame_write_done             writer finished the frame in wr_bank
//   frame_read_sync              LCD is about to fetch a new frame
//   cnt_clr                      clear drop/repeat statistics
//   wr_bank, rd_bank             bank being written / displayed
//   wr_load, rd_load             one-cycle address reload pulses
//   wr_hold                      writer must stall (double mode, no free bank)
//   ready_valid                  a finished, undisplayed frame exists
//   drop_cnt, rep_cnt            saturating dropped / repeated frame counters
module frame_bank_mgr #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BANK_W    = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              freeze,
  input  logic              frame_write_done,
  input  logic              frame_read_sync,
  input  logic              cnt_clr,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] rd_bank,
  output logic              wr_load,
  output logic              rd_load,
  output logic              wr_hold,
  output logic              ready_valid,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  rep_cnt
);

  typedef enum logic [1:0] {
    BK_FREE    = 2'd0,
    BK_WRITING = 2'd1,
    BK_READY   = 2'd2,
    BK_READING = 2'd3
  } bank_st_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctl_st_e;

  // Power-up bank roles: display bank 0, write bank 1.
  function automatic bank_st_e reset_bank(input int unsigned idx);
    bank_st_e st;
    st = BK_FREE;
    if (idx == 0) st = BK_READING;
    else if (idx == 1) st = BK_WRITING;
    return st;
  endfunction

  ctl_st_e           ctl_q, ctl_d;
  logic [1:0]        mode_q, mode_d;
  bank_st_e          bank_q [NUM_BANKS];
  bank_st_e          bank_d [NUM_BANKS];
  logic [BANK_W-1:0] wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic              wr_load_q, wr_load_d, rd_load_q, rd_load_d;
  logic              wr_hold_q, wr_hold_d, ready_valid_q, ready_valid_d;
  logic [CNT_W-1:0]  drop_q, drop_d, rep_q, rep_d;

  logic              use_triple;
  int unsigned       num_used;
  logic              rel_found, wr_found, rdy_any, rdy_next;
  logic              drop_inc, rep_inc;

  // State register
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      ctl_q         <= ST_INIT;
      mode_q        <= 2'd0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) bank_q[i] <= reset_bank(i);
      wr_bank_q     <= BANK_W'(1);
      rd_bank_q     <= '0;
      wr_load_q     <= 1'b0;
      rd_load_q     <= 1'b0;
      wr_hold_q     <= 1'b0;
      ready_valid_q <= 1'b0;
      drop_q        <= '0;
      rep_q         <= '0;
    end else begin
      ctl_q         <= ctl_d;
      mode_q        <= mode_d;
      bank_q        <= bank_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_load_q     <= wr_load_d;
      rd_load_q     <= rd_load_d;
      wr_hold_q     <= wr_hold_d;
      ready_valid_q <= ready_valid_d;
      drop_q        <= drop_d;
      rep_q         <= rep_d;
    end
  end

  // Next-state: init/reinit control and bank role arbitration
  always_comb begin
    ctl_d         = ctl_q;
    mode_d        = mode_q;
    bank_d        = bank_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_load_d     = 1'b0;
    rd_load_d     = 1'b0;
    wr_hold_d     = wr_hold_q;
    rel_found     = 1'b0;
    wr_found      = 1'b0;
    rdy_any       = 1'b0;
    rdy_next      = 1'b0;
    drop_inc      = 1'b0;
    rep_inc       = 1'b0;
    // Mode 3 aliases triple; triple with only two banks degrades to double.
    use_triple    = mode_q[1] && (NUM_BANKS >= 3);
    // Double buffering ping-pongs between banks 0 and 1 only.
    num_used      = use_triple ? NUM_BANKS : 32'd2;

    case (ctl_q)
      ST_INIT: begin
        mode_d = mode;
        if (enable) begin
          ctl_d     = ST_RUN;
          wr_load_d = 1'b1;
          rd_load_d = 1'b1;
          wr_bank_d = (mode == 2'd0) ? '0 : BANK_W'(1);
        end
      end
      ST_RUN: begin
        if (mode != mode_q) begin
          // Reinit: back to power-up roles, counters survive.
          ctl_d = ST_INIT;
          for (int unsigned i = 0; i < NUM_BANKS; i++) bank_d[i] = reset_bank(i);
          wr_bank_d = (mode == 2'd0) ? '0 : BANK_W'(1);
          rd_bank_d = '0;
          wr_hold_d = 1'b0;
        end else if (enable && (mode_q == 2'd0)) begin
          wr_load_d = frame_write_done;
          rd_load_d = frame_read_sync;
        end else if (enable) begin
          if (wr_hold_q) begin
            // Stalled writer grabs a bank freed by the previous sync.
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
              if (!rel_found && (i < num_used) && (bank_d[i] == BK_FREE)) begin
                rel_found = 1'b1;
                bank_d[i] = BK_WRITING;
                wr_bank_d = BANK_W'(i);
                wr_load_d = 1'b1;
                wr_hold_d = 1'b0;
              end
            end
          end else if (frame_write_done) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
              if (use_triple && (bank_d[i] == BK_READY)) begin
                bank_d[i] = BK_FREE;
                drop_inc  = 1'b1;
              end
            end
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
              if (bank_d[i] == BK_WRITING) bank_d[i] = BK_READY;
            end
          end

          // Sync sees the frame completed in this same cycle.
          if (frame_read_sync) begin
            rd_load_d = 1'b1;
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
              if (bank_d[i] == BK_READY) rdy_any = 1'b1;
            end
            if (rdy_any && !freeze) begin
              for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                if (bank_d[i] == BK_READING) begin
                  bank_d[i] = BK_FREE;
                end else if (bank_d[i] == BK_READY) begin
                  bank_d[i] = BK_READING;
                  rd_bank_d = BANK_W'(i);
                end
              end
            end else if (!freeze) begin
              rep_inc = 1'b1;
            end
          end

          // New write bank chosen after any swap so a freed bank is usable.
          if (frame_write_done && !wr_hold_q) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
              if (!wr_found && (i < num_used) && (bank_d[i] == BK_FREE)) begin
                wr_found  = 1'b1;
                bank_d[i] = BK_WRITING;
                wr_bank_d = BANK_W'(i);
                wr_load_d = 1'b1;
              end
            end
            if (!wr_found) wr_hold_d = 1'b1;
          end
        end
      end
      default: ctl_d = ST_INIT;
    endcase

    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (bank_d[i] == BK_READY) rdy_next = 1'b1;
    end
    ready_valid_d = rdy_next;

    // Statistics: clear wins over increment, saturate at all-ones.
    drop_d = drop_q;
    rep_d  = rep_q;
    if (cnt_clr) begin
      drop_d = '0;
      rep_d  = '0;
    end else begin
      if (drop_inc && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
      if (rep_inc && (rep_q != '1))   rep_d  = rep_q + CNT_W'(1);
    end
  end

  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign wr_load     = wr_load_q;
  assign rd_load     = rd_load_q;
  assign wr_hold     = wr_hold_q;
  assign ready_valid = ready_valid_q;
  assign drop_cnt    = drop_q;
  assign rep_cnt     = rep_q;

endmodule

// File: tb/tb_frame_bank_mgr.sv
// tb_frame_bank_mgr: table-driven directed bench for frame_bank_mgr. A second
// instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_frame_bank_mgr;

  logic        clk_ref = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic        freeze;
  logic        frame_write_done;
  logic        frame_read_sync;
  logic        cnt_clr;

  logic [1:0]  wr_bank, rd_bank;
  logic        wr_load, rd_load, wr_hold, ready_valid;
  logic [15:0] drop_cnt, rep_cnt;

  logic [1:0]  s_wr_bank, s_rd_bank;
  logic        s_wr_load, s_rd_load, s_wr_hold, s_ready_valid;
  logic [1:0]  s_drop_cnt, s_rep_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_ref = ~clk_ref;

  frame_bank_mgr #(.NUM_BANKS(4), .BANK_W(2), .CNT_W(16)) dut (
    .clk_ref(clk_ref), .rst(rst), .enable(enable), .mode(mode), .freeze(freeze),
    .frame_write_done(frame_write_done), .frame_read_sync(frame_read_sync),
    .cnt_clr(cnt_clr), .wr_bank(wr_bank), .rd_bank(rd_bank), .wr_load(wr_load),
    .rd_load(rd_load), .wr_hold(wr_hold), .ready_valid(ready_valid),
    .drop_cnt(drop_cnt), .rep_cnt(rep_cnt)
  );

  frame_bank_mgr #(.NUM_BANKS(4), .BANK_W(2), .CNT_W(2)) dut_s (
    .clk_ref(clk_ref), .rst(rst), .enable(enable), .mode(mode), .freeze(freeze),
    .frame_write_done(frame_write_done), .frame_read_sync(frame_read_sync),
    .cnt_clr(cnt_clr), .wr_bank(s_wr_bank), .rd_bank(s_rd_bank), .wr_load(s_wr_load),
    .rd_load(s_rd_load), .wr_hold(s_wr_hold), .ready_valid(s_ready_valid),
    .drop_cnt(s_drop_cnt), .rep_cnt(s_rep_cnt)
  );

  typedef struct {
    logic        en;
    logic [1:0]  md;
    logic        frz, dn, sy, clr;
    logic [1:0]  wb, rb;
    logic        wl, rl, wh, rv;
    logic [15:0] dc, rc;
    logic [1:0]  rcs;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic en, input logic [1:0] md, input logic frz,
                              input logic dn, input logic sy, input logic clr,
                              input logic [1:0] wb, input logic [1:0] rb,
                              input logic wl, input logic rl, input logic wh,
                              input logic rv, input logic [15:0] dc,
                              input logic [15:0] rc, input logic [1:0] rcs);
    vec_t v;
    v.en = en; v.md = md; v.frz = frz; v.dn = dn; v.sy = sy; v.clr = clr;
    v.wb = wb; v.rb = rb; v.wl = wl; v.rl = rl; v.wh = wh; v.rv = rv;
    v.dc = dc; v.rc = rc; v.rcs = rcs;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_ref);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd2; freeze = 1'b0;
    frame_write_done = 1'b0; frame_read_sync = 1'b0; cnt_clr = 1'b0;

    //  en md frz dn sy clr | wb rb wl rl wh rv dc rc rcs
    add(1, 2, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0, 0, 0, 0);  // 0 init pulses
    add(1, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 1, 0, 0,  2, 0, 1, 0, 0, 1, 0, 0, 0);  // 2 done -> wr 2
    add(1, 2, 0, 0, 1, 0,  2, 1, 0, 1, 0, 0, 0, 0, 0);  // 3 sync -> rd 1
    add(1, 2, 0, 1, 0, 0,  0, 1, 1, 0, 0, 1, 0, 0, 0);  // 4..6 three dones
    add(1, 2, 0, 1, 0, 0,  2, 1, 1, 0, 0, 1, 1, 0, 0);
    add(1, 2, 0, 1, 0, 0,  0, 1, 1, 0, 0, 1, 2, 0, 0);
    add(1, 2, 0, 0, 1, 0,  0, 2, 0, 1, 0, 0, 2, 0, 0);  // 7 shows last written
    add(1, 2, 0, 0, 1, 0,  0, 2, 0, 1, 0, 0, 2, 1, 1);  // 8 repeat
    add(1, 2, 0, 1, 1, 0,  1, 0, 1, 1, 0, 0, 2, 1, 1);  // 9 done+sync
    add(1, 2, 0, 1, 0, 0,  2, 0, 1, 0, 0, 1, 2, 1, 1);
    add(1, 2, 1, 0, 1, 0,  2, 0, 0, 1, 0, 1, 2, 1, 1);  // 11 frozen
    add(1, 2, 0, 0, 1, 0,  2, 1, 0, 1, 0, 0, 2, 1, 1);
    add(0, 2, 0, 1, 0, 0,  2, 1, 0, 0, 0, 0, 2, 1, 1);  // 13,14 disabled
    add(0, 2, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0, 2, 1, 1);
    add(1, 2, 0, 0, 0, 1,  2, 1, 0, 0, 0, 0, 0, 0, 0);  // 15 clear
    add(1, 2, 0, 0, 1, 0,  2, 1, 0, 1, 0, 0, 0, 1, 1);  // 16..20 repeats
    add(1, 2, 0, 0, 1, 0,  2, 1, 0, 1, 0, 0, 0, 2, 2);
    add(1, 2, 0, 0, 1, 0,  2, 1, 0, 1, 0, 0, 0, 3, 3);
    add(1, 2, 0, 0, 1, 0,  2, 1, 0, 1, 0, 0, 0, 4, 3);
    add(1, 2, 0, 0, 1, 0,  2, 1, 0, 1, 0, 0, 0, 5, 3);
    add(1, 2, 0, 0, 1, 1,  2, 1, 0, 1, 0, 0, 0, 0, 0);  // 21 clear beats inc
    add(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);  // 22 reinit to mode 1
    add(1, 1, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0,  1, 0, 0, 0, 1, 1, 0, 0, 0);  // 24 hold
    add(1, 1, 0, 1, 0, 0,  1, 0, 0, 0, 1, 1, 0, 0, 0);  // 25 dup done ignored
    add(1, 1, 0, 0, 1, 0,  1, 1, 0, 1, 1, 0, 0, 0, 0);  // 26 swap
    add(1, 1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0);  // 27 hold release
    add(1, 1, 0, 1, 1, 0,  1, 0, 1, 1, 0, 0, 0, 0, 0);  // 28 done+sync, no hold
    add(1, 1, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1);  // 30 reinit to mode 0
    add(1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1);

    cycle();
    cycle();
    chk("reset wr_bank", -1, 32'(wr_bank), 32'd1);
    chk("reset rd_bank", -1, 32'(rd_bank), 32'd0);
    chk("reset wr_load", -1, 32'(wr_load), 32'd0);
    chk("reset rd_load", -1, 32'(rd_load), 32'd0);
    chk("reset wr_hold", -1, 32'(wr_hold), 32'd0);
    chk("reset ready_valid", -1, 32'(ready_valid), 32'd0);
    chk("reset drop_cnt", -1, 32'(drop_cnt), 32'd0);
    chk("reset rep_cnt", -1, 32'(rep_cnt), 32'd0);
    rst = 1'b0;

    foreach (vq[k]) begin
      enable = vq[k].en; mode = vq[k].md; freeze = vq[k].frz;
      frame_write_done = vq[k].dn; frame_read_sync = vq[k].sy; cnt_clr = vq[k].clr;
      cycle();
      chk("wr_bank", k, 32'(wr_bank), 32'(vq[k].wb));
      chk("rd_bank", k, 32'(rd_bank), 32'(vq[k].rb));
      chk("wr_load", k, 32'(wr_load), 32'(vq[k].wl));
      chk("rd_load", k, 32'(rd_load), 32'(vq[k].rl));
      chk("wr_hold", k, 32'(wr_hold), 32'(vq[k].wh));
      chk("ready_valid", k, 32'(ready_valid), 32'(vq[k].rv));
      chk("drop_cnt", k, 32'(drop_cnt), 32'(vq[k].dc));
      chk("rep_cnt", k, 32'(rep_cnt), 32'(vq[k].rc));
      chk("rep_cnt_sat", k, 32'(s_rep_cnt), 32'(vq[k].rcs));
    end
    frame_write_done = 1'b0; frame_read_sync = 1'b0; cnt_clr = 1'b0; freeze = 1'b0;

    // Asynchronous reset in the middle of a triple-buffered frame.
    mode = 2'd2;
    cycle();                       // reinit
    cycle();                       // init pulses
    frame_write_done = 1'b1;
    cycle();
    frame_write_done = 1'b0;
    chk("pre-rst wr_bank", 100, 32'(wr_bank), 32'd2);
    chk("pre-rst ready_valid", 100, 32'(ready_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst wr_bank", 101, 32'(wr_bank), 32'd1);
    chk("async rst rd_bank", 101, 32'(rd_bank), 32'd0);
    chk("async rst ready_valid", 101, 32'(ready_valid), 32'd0);
    chk("async rst rep_cnt", 101, 32'(rep_cnt), 32'd0);
    chk("async rst wr_load", 101, 32'(wr_load), 32'd0);
    enable = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    chk("idle wr_load", 102, 32'(wr_load), 32'd0);
    chk("idle rd_load", 102, 32'(rd_load), 32'd0);
    cycle();
    chk("idle2 rd_load", 103, 32'(rd_load), 32'd0);
    enable = 1'b1;
    cycle();
    chk("re-enable wr_load", 104, 32'(wr_load), 32'd1);
    chk("re-enable rd_load", 104, 32'(rd_load), 32'd1);
    chk("re-enable wr_bank", 104, 32'(wr_bank), 32'd1);
    cycle();
    chk("single pulse wr_load", 105, 32'(wr_load), 32'd0);
    chk("single pulse rd_load", 105, 32'(rd_load), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
